// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures the decoded control bundle and register specifiers into EX.
// A bubble is inserted on a taken-branch flush or on a load-use stall.
// The stall also holds PC and IF/ID.
// Optional stall statistics counter: define ID_EX_STALL_COUNTER_EN.
module id_ex_stage #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_branch,
  input  logic                  id_mem_read,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic [1:0]            id_alu_op,
  input  logic                  id_reg_dst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic                  ex_reg_dst,
  output logic [1:0]            ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  stall,
  output logic                  pc_write,
  output logic                  ifid_write
`ifdef ID_EX_STALL_COUNTER_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_count
`endif
);

  // Counter width of zero makes no sense, even when the counter is compiled out.
  if (STALL_CNT_W < 1) begin : g_cnt_w_check
    $error("STALL_CNT_W must be at least 1");
  end

  logic hz;
  logic load_bubble;

  // Load-use hazard: EX holds a real load whose destination is read by ID.
  // rs2 is compared even for I-type/loads; the occasional false stall is accepted.
  always_comb begin
    hz = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
         ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    stall       = hz & ~flush;
    pc_write    = ~stall;
    ifid_write  = ~stall;
    // Flush, stall and an invalid ID slot all produce the same all-zero bubble,
    // so the priority order collapses into one select.
    load_bubble = flush | stall | ~id_valid;
  end

  // EX register: bubble or sanitised capture of the ID bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_op     <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
    end else if (load_bubble) begin
      ex_valid      <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_op     <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
    end else begin
      ex_valid      <= 1'b1;
      ex_branch     <= id_branch;
      ex_mem_read   <= id_mem_read;
      // MemtoReg/RegDst are don't-care from the decoder when nothing is written back.
      ex_mem_to_reg <= id_reg_write ? id_mem_to_reg : 1'b0;
      ex_mem_write  <= id_mem_write;
      ex_alu_src    <= id_alu_src;
      ex_reg_write  <= id_reg_write;
      ex_reg_dst    <= id_reg_write ? id_reg_dst : 1'b0;
      ex_alu_op     <= id_alu_op;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
    end
  end

`ifdef ID_EX_STALL_COUNTER_EN
  // Saturating count of stalled edges; flush cycles never stall so are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares them.
// Counter checks are active when ID_EX_STALL_COUNTER_EN is defined.
module tb_id_ex_stage;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 2;

  typedef struct packed {
    logic valid, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0] alu_op;
    logic reg_dst;
    logic [AW-1:0] rs1, rs2, rd;
  } id_t;

  typedef struct {
    logic [24:0] ex;
    logic        s;
    int          c;
    string       tag;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  id_t  id = '0;

  logic ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write;
  logic ex_alu_src, ex_reg_write, ex_reg_dst;
  logic [1:0] ex_alu_op;
  logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic stall, pc_write, ifid_write;
`ifdef ID_EX_STALL_COUNTER_EN
  logic [CW-1:0] stall_count;
`endif

  rec_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id.valid), .id_branch(id.branch), .id_mem_read(id.mem_read),
    .id_mem_to_reg(id.mem_to_reg), .id_mem_write(id.mem_write),
    .id_alu_src(id.alu_src), .id_reg_write(id.reg_write), .id_alu_op(id.alu_op),
    .id_reg_dst(id.reg_dst), .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .flush(flush),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_reg_dst(ex_reg_dst),
    .ex_alu_op(ex_alu_op), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write)
`ifdef ID_EX_STALL_COUNTER_EN
    , .stall_count(stall_count)
`endif
  );

  // ID-side builders; X fields of the decoder are driven as 1 (worst case).
  function automatic id_t mk(logic v, logic br, logic mr, logic m2r, logic mw,
                             logic as, logic rw, logic [1:0] op, logic rdst,
                             logic [AW-1:0] a, logic [AW-1:0] b, logic [AW-1:0] d);
    return {v, br, mr, m2r, mw, as, rw, op, rdst, a, b, d};
  endfunction
  function automatic id_t i_rt(logic [AW-1:0] a, logic [AW-1:0] b, logic [AW-1:0] d);
    return mk(1, 0, 0, 0, 0, 0, 1, 2'b10, 1, a, b, d);
  endfunction
  function automatic id_t i_ld(logic [AW-1:0] a, logic [AW-1:0] d);
    return mk(1, 0, 1, 1, 0, 1, 1, 2'b00, 0, a, 5'd0, d);
  endfunction
  function automatic id_t i_sd(logic [AW-1:0] a, logic [AW-1:0] b, logic [AW-1:0] d);
    return mk(1, 0, 0, 1, 1, 1, 0, 2'b00, 1, a, b, d);
  endfunction
  function automatic id_t i_beq(logic [AW-1:0] a, logic [AW-1:0] b);
    return mk(1, 1, 0, 1, 0, 0, 0, 2'b01, 1, a, b, 5'd0);
  endfunction
  function automatic id_t i_nop();
    return mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 5'd3, 5'd3, 5'd3);
  endfunction
  function automatic id_t i_rnd();
    logic [24:0] t;
    t = 25'($urandom);
    return t;
  endfunction

  // EX-side expectations: valid,branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write,reg_dst,alu_op,rs1,rs2,rd
  function automatic logic [24:0] ev(logic v, logic br, logic mr, logic m2r, logic mw,
                                     logic as, logic rw, logic rdst, logic [1:0] op,
                                     logic [AW-1:0] a, logic [AW-1:0] b, logic [AW-1:0] d);
    return {v, br, mr, m2r, mw, as, rw, rdst, op, a, b, d};
  endfunction
  function automatic logic [24:0] e_rt(logic [AW-1:0] a, logic [AW-1:0] b, logic [AW-1:0] d);
    return ev(1, 0, 0, 0, 0, 0, 1, 1, 2'b10, a, b, d);
  endfunction
  function automatic logic [24:0] e_ld(logic [AW-1:0] a, logic [AW-1:0] d);
    return ev(1, 0, 1, 1, 0, 1, 1, 0, 2'b00, a, 5'd0, d);
  endfunction
  function automatic logic [24:0] e_sd(logic [AW-1:0] a, logic [AW-1:0] b, logic [AW-1:0] d);
    return ev(1, 0, 0, 0, 1, 1, 0, 0, 2'b00, a, b, d);
  endfunction
  function automatic logic [24:0] e_beq(logic [AW-1:0] a, logic [AW-1:0] b);
    return ev(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, a, b, 5'd0);
  endfunction
  function automatic int sat3(int k);
    return (k > 3) ? 3 : k;
  endfunction

  localparam logic [24:0] BUB = '0;
  localparam int R_HIGH = 0, R_LOW = 1, R_MID = 2;

  // One cycle: apply ID inputs just after the edge and queue the expectation
  // (EX contents from that edge, stall for the newly applied inputs).
  task automatic step(input string tag, input id_t i, input logic fl,
                      input logic [24:0] e, input logic s, input int c, input int r);
    rec_t rec;
    @(posedge clk);
    #1;
    id    = i;
    flush = fl;
    rst_n = (r == R_LOW) ? 1'b0 : 1'b1;
    if (r == R_MID) begin
      #1 rst_n = 1'b0;
    end
    rec.ex = e; rec.s = s; rec.c = c; rec.tag = tag;
    sb.push_back(rec);
  endtask

  // Monitor: compare DUT state with the oldest expectation at each negedge.
  initial begin
    rec_t r;
    logic [24:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        act = {ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
               ex_alu_src, ex_reg_write, ex_reg_dst, ex_alu_op, ex_rs1, ex_rs2, ex_rd};
        n_cmp++;
        if (act !== r.ex) begin
          n_bad++;
          $display("FAIL %s ex_bundle: got %h want %h", r.tag, act, r.ex);
        end
        n_cmp++;
        if ({stall, pc_write, ifid_write} !== {r.s, ~r.s, ~r.s}) begin
          n_bad++;
          $display("FAIL %s stall/pc_write/ifid_write: got %b want %b", r.tag,
                   {stall, pc_write, ifid_write}, {r.s, ~r.s, ~r.s});
        end
`ifdef ID_EX_STALL_COUNTER_EN
        n_cmp++;
        if (int'(stall_count) != r.c) begin
          n_bad++;
          $display("FAIL %s stall_count: got %0d want %0d", r.tag, stall_count, r.c);
        end
`endif
      end
    end
  end

  initial begin
    logic [24:0] prev;
    step("rst0", i_rnd(), 1'($urandom), BUB, 0, 0, R_LOW);
    step("rst1", i_rnd(), 1'($urandom), BUB, 0, 0, R_LOW);
    step("release", i_rt(1, 2, 5), 0, BUB, 0, 0, R_HIGH);
    step("rtype_cap", i_ld(1, 7), 0, e_rt(1, 2, 5), 0, 0, R_HIGH);
    step("lu_stall", i_rt(7, 8, 10), 0, e_ld(1, 7), 1, 0, R_HIGH);
    step("lu_bubble", i_rt(7, 8, 10), 0, BUB, 0, 1, R_HIGH);
    step("lu_resume", i_ld(0, 0), 0, e_rt(7, 8, 10), 0, 1, R_HIGH);
    step("x0_nostall", i_rt(0, 0, 11), 0, e_ld(0, 0), 0, 1, R_HIGH);
    step("x0_after", i_ld(2, 3), 0, e_rt(0, 0, 11), 0, 1, R_HIGH);
    step("nomatch", i_rt(4, 6, 12), 0, e_ld(2, 3), 0, 1, R_HIGH);
    step("pre_flush", i_ld(1, 9), 0, e_rt(4, 6, 12), 0, 1, R_HIGH);
    step("flush_wins", i_rt(1, 9, 13), 1, e_ld(1, 9), 0, 1, R_HIGH);
    step("flush_bubble", i_sd(2, 4, 0), 0, BUB, 0, 1, R_HIGH);
    step("sd_sanitise", i_beq(3, 3), 0, e_sd(2, 4, 0), 0, 1, R_HIGH);
    step("beq_sanitise", i_nop(), 0, e_beq(3, 3), 0, 1, R_HIGH);
    step("invalid_bubble", i_ld(1, 14), 0, BUB, 0, 1, R_HIGH);
    step("b2b_stall1", i_ld(14, 15), 0, e_ld(1, 14), 1, 1, R_HIGH);
    step("b2b_bub1", i_ld(14, 15), 0, BUB, 0, 2, R_HIGH);
    step("b2b_stall2_rs2", i_rt(2, 15, 16), 0, e_ld(14, 15), 1, 2, R_HIGH);
    step("b2b_bub2", i_rt(2, 15, 16), 0, BUB, 0, 3, R_HIGH);
    step("b2b_done", i_ld(1, 17), 0, e_rt(2, 15, 16), 0, 3, R_HIGH);
    step("mid_stall_rst", i_rt(17, 0, 18), 0, BUB, 0, 0, R_MID);
    step("rst_held", i_rt(17, 0, 18), 0, BUB, 0, 0, R_LOW);
    step("rst_release", i_rt(17, 0, 18), 0, BUB, 0, 0, R_HIGH);
    step("first_cap", i_nop(), 0, e_rt(17, 0, 18), 0, 0, R_HIGH);
    for (int k = 0; k < 5; k++) begin
      prev = (k == 0) ? BUB : e_rt(20, 0, 21);
      step($sformatf("sat_ld%0d", k), i_ld(1, 20), 0, prev, 0, sat3(k), R_HIGH);
      step($sformatf("sat_stall%0d", k), i_rt(20, 0, 21), 0, e_ld(1, 20), 1, sat3(k), R_HIGH);
      step($sformatf("sat_bub%0d", k), i_rt(20, 0, 21), 0, BUB, 0, sat3(k + 1), R_HIGH);
    end
    step("tail_rt", i_nop(), 0, e_rt(20, 0, 21), 0, 3, R_HIGH);
    step("tail_bub", i_nop(), 0, BUB, 0, 3, R_HIGH);
    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
